// File: rtl/sc_spi_pkg.sv
// Shared definitions for the SPI target engine: FSM states and SPI mode encoding.
package sc_spi_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    // Bit positions inside the 2-bit mode field
    localparam int unsigned CPOL_BIT = 1;
    localparam int unsigned CPHA_BIT = 0;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/sc_spi_sync.sv
// Single-bit multi-flop synchroniser with a configurable reset value.
module sc_spi_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sc_spi_tgt.sv
// SPI target protocol engine: oversamples SCLK/CSB/MOSI in the SRCCLK domain,
// deserialises MOSI into words and serialises a holding-register TX stream on MISO.
// Optional LSB-first support is enabled with the SC_SPI_TGT_LSBF_EN macro.
module sc_spi_tgt
    import sc_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_WIDTH  = 8
) (
    input  logic                  SRCCLK,
    input  logic                  SYSRSTB,
    input  logic                  CLK_ENABLE,
    input  logic [1:0]            CLK_MODE,
`ifdef SC_SPI_TGT_LSBF_EN
    input  logic                  CLK_LSBF,
`endif
    input  logic                  SPI_SCLK,
    input  logic                  SPI_CSB,
    input  logic                  SPI_MOSI,
    output logic                  SPI_MISO,
    output logic                  SPI_MISO_OE,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic                  TX_VALID,
    output logic                  TX_READY,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  RX_VALID,
    output logic                  TX_UNDERRUN,
    output logic                  FRAME_ABORT,
    output logic                  BUSY
);

    localparam int unsigned     CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    spi_state_e            state_q, state_d;
    logic                  sclk_s, csb_s, mosi_s;
    logic                  sclk_d, csb_d;
    logic                  sclk_rise, sclk_fall, csb_fall;
    logic                  sample_edge, shift_edge;
    logic [1:0]            mode_q;
    logic                  lsbf;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_next, rx_data_q;
    logic [DATA_WIDTH-1:0] tx_sh_q, hold_q;
    logic                  tx_ready_q, rx_valid_q, underrun_q, abort_q;
    logic                  start_c, abort_c, sample_c, shift_c, load_c, wr_c;

    // Bring the pad signals into the SRCCLK domain
    sc_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(SRCCLK), .rst_n(SYSRSTB), .d(SPI_SCLK), .q(sclk_s));
    sc_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
        .clk(SRCCLK), .rst_n(SYSRSTB), .d(SPI_CSB), .q(csb_s));
    sc_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(SRCCLK), .rst_n(SYSRSTB), .d(SPI_MOSI), .q(mosi_s));

    assign sclk_rise   = sclk_s & ~sclk_d;
    assign sclk_fall   = ~sclk_s & sclk_d;
    assign csb_fall    = ~csb_s & csb_d;
    // Modes 0/3 sample on rising SCLK, modes 1/2 on falling
    assign sample_edge = (mode_q[CPOL_BIT] == mode_q[CPHA_BIT]) ? sclk_rise : sclk_fall;
    assign shift_edge  = (mode_q[CPOL_BIT] == mode_q[CPHA_BIT]) ? sclk_fall : sclk_rise;
    assign wr_c        = TX_VALID & tx_ready_q;
    assign rx_next     = lsbf ? {mosi_s, rx_sh_q[DATA_WIDTH-1:1]}
                              : {rx_sh_q[DATA_WIDTH-2:0], mosi_s};

`ifdef SC_SPI_TGT_LSBF_EN
    logic lsbf_q;

    // Bit order is fixed for the whole frame
    always_ff @(posedge SRCCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            lsbf_q <= 1'b0;
        end else if (start_c) begin
            lsbf_q <= CLK_LSBF;
        end
    end

    assign lsbf = lsbf_q;
`else
    assign lsbf = 1'b0;
`endif

    // State register
    always_ff @(posedge SRCCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle datapath strobes
    always_comb begin
        state_d  = state_q;
        start_c  = 1'b0;
        abort_c  = 1'b0;
        sample_c = 1'b0;
        shift_c  = 1'b0;
        load_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CLK_ENABLE && csb_fall) begin
                    state_d = ST_ACTIVE;
                    start_c = 1'b1;
                    load_c  = ~CLK_MODE[CPHA_BIT];
                end
            end
            ST_ACTIVE: begin
                if (!CLK_ENABLE) begin
                    state_d = ST_IDLE;
                end else if (csb_s) begin
                    state_d = ST_IDLE;
                    abort_c = (bit_cnt_q != '0);
                end else if (sample_edge) begin
                    sample_c = 1'b1;
                    load_c   = (bit_cnt_q == LAST_BIT) & ~mode_q[CPHA_BIT];
                end else if (shift_edge) begin
                    // At a word boundary the shift edge either loads (CPHA=1) or is ignored
                    if (bit_cnt_q == '0) begin
                        load_c = mode_q[CPHA_BIT];
                    end else begin
                        shift_c = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shift registers, holding register and status pulses
    always_ff @(posedge SRCCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            sclk_d     <= 1'b0;
            csb_d      <= 1'b1;
            mode_q     <= SPI_MODE0;
            bit_cnt_q  <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_sh_q    <= '0;
            hold_q     <= '0;
            tx_ready_q <= 1'b1;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            sclk_d     <= sclk_s;
            csb_d      <= csb_s;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= abort_c;
            if (start_c) begin
                mode_q    <= CLK_MODE;
                bit_cnt_q <= '0;
            end
            if (sample_c) begin
                rx_sh_q <= rx_next;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_q  <= '0;
                    rx_data_q  <= rx_next;
                    rx_valid_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                end
            end
            if (load_c) begin
                if (!tx_ready_q) begin
                    tx_sh_q    <= hold_q;
                    tx_ready_q <= 1'b1;
                end else if (TX_VALID) begin
                    // Simultaneous write bypasses the empty holding register
                    tx_sh_q <= TX_DATA;
                end else begin
                    tx_sh_q    <= '1;
                    underrun_q <= 1'b1;
                end
            end else begin
                if (shift_c) begin
                    tx_sh_q <= lsbf ? (tx_sh_q >> 1) : (tx_sh_q << 1);
                end
                if (wr_c) begin
                    hold_q     <= TX_DATA;
                    tx_ready_q <= 1'b0;
                end
            end
        end
    end

    assign SPI_MISO    = lsbf ? tx_sh_q[0] : tx_sh_q[DATA_WIDTH-1];
    assign BUSY        = (state_q == ST_ACTIVE);
    assign SPI_MISO_OE = BUSY;
    assign TX_READY    = tx_ready_q;
    assign RX_DATA     = rx_data_q;
    assign RX_VALID    = rx_valid_q;
    assign TX_UNDERRUN = underrun_q;
    assign FRAME_ABORT = abort_q;

endmodule
